// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8 multi-cycle controller.
// Holds opcode patterns with their don't-care masks, the instruction class
// and sequencer state enums, and the ALUOp / ALUSrc encodings.
package cpu_pkg;

  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_ADD    = 11'b10001011000;
  localparam logic [10:0] OP_SUB    = 11'b11001011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_ORR    = 11'b10101010000;
  localparam logic [10:0] OP_ADDI   = 11'b10010001000;
  localparam logic [10:0] OP_CBZ    = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ   = 11'b10110101000;
  localparam logic [10:0] OP_B      = 11'b00010100000;
  localparam logic [10:0] OP_HALT   = 11'b11111111111;

  // A 1 in a mask marks a bit that must match; 0 is don't-care.
  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_ADDI = 11'b11111111110;
  localparam logic [10:0] MASK_CB   = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;

  typedef enum logic [3:0] {
    CLS_LD, CLS_ST, CLS_R, CLS_ADDI, CLS_CBZ, CLS_CBNZ, CLS_B, CLS_HALT, CLS_ILL
  } op_class_t;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_ERR
  } state_t;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_PASS_B = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] ALUSRC_REG   = 2'b00;
  localparam logic [1:0] ALUSRC_DOFS  = 2'b01;
  localparam logic [1:0] ALUSRC_IMM   = 2'b10;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] mask);
    return ((op ^ pat) & mask) == 11'd0;
  endfunction

endpackage

// File: rtl/cpu_multicycle_ctrl_if.sv
// Memory handshake bundle between the sequencer and the instruction/data
// memories.
//   imem_req / imem_ack : instruction fetch request / data valid
//   dmem_req / dmem_we  : data access request / access is a write
//   dmem_ack            : read data valid or write accepted
// master = controller side, slave = memory side.
interface cpu_multicycle_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we,
                  input  imem_ack, dmem_ack);
  modport slave  (input  imem_req, dmem_req, dmem_we,
                  output imem_ack, dmem_ack);
endinterface

// File: rtl/cpu_opcode_class.sv
// Combinational decoder from the 11-bit opcode field to an instruction class.
//   opcode   : inst31_21 from the instruction register
//   op_class : decoded class, CLS_ILL for anything not recognised
module cpu_opcode_class
  import cpu_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class
);

  always_comb begin
    op_class = CLS_ILL;
    if      (op_match(opcode, OP_LDUR, MASK_FULL)) op_class = CLS_LD;
    else if (op_match(opcode, OP_STUR, MASK_FULL)) op_class = CLS_ST;
    else if (op_match(opcode, OP_ADD,  MASK_FULL) ||
             op_match(opcode, OP_SUB,  MASK_FULL) ||
             op_match(opcode, OP_AND,  MASK_FULL) ||
             op_match(opcode, OP_ORR,  MASK_FULL)) op_class = CLS_R;
    else if (op_match(opcode, OP_ADDI, MASK_ADDI)) op_class = CLS_ADDI;
    else if (op_match(opcode, OP_CBZ,  MASK_CB))   op_class = CLS_CBZ;
    else if (op_match(opcode, OP_CBNZ, MASK_CB))   op_class = CLS_CBNZ;
    else if (op_match(opcode, OP_B,    MASK_B))    op_class = CLS_B;
    else if (op_match(opcode, OP_HALT, MASK_FULL)) op_class = CLS_HALT;
  end

endmodule

// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle sequencer for the LEGv8 datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, stalls on the
// memory acks, and counts retired instructions.
//
// state     | meaning
// ----------+----------------------------------------------
// ST_FETCH  | request instruction, load IR and PC+4 on ack
// ST_DECODE | register read; reg2loc for STUR/CB*
// ST_EXEC   | ALU step; branches, HALT, illegal resolve here
// ST_MEM    | data access, held until dmem_ack
// ST_WB     | register file write
// ST_HALT   | terminal after HALT, until reset
// ST_ERR    | terminal after illegal opcode, until reset
//
// Ports: clk, rst_n (sync, active low), inst31_21, alu_zero, mem (memory
// handshake, master side), datapath strobes, halted/illegal (sticky),
// retired (wrapping count).
module cpu_multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int ADDR_SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [10:0]            inst31_21,
  input  logic                   alu_zero,
  cpu_multicycle_ctrl_if.master  mem,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic                   reg2loc,
  output logic [ADDR_SEL_W-1:0]  alu_src,
  output logic [1:0]             alu_op,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   halted,
  output logic                   illegal,
  output logic [CNT_W-1:0]       retired
);

  state_t    state, state_nxt;
  op_class_t cls;
  logic      taken;
  logic      retire, set_halt, set_ill;
  logic [1:0] alu_src_c;

  cpu_opcode_class u_class (
    .opcode   (inst31_21),
    .op_class (cls)
  );

  assign taken = (cls == CLS_CBZ  &&  alu_zero) ||
                 (cls == CLS_CBNZ && !alu_zero);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_FETCH;
      halted  <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (set_halt) halted  <= 1'b1;
      if (set_ill)  illegal <= 1'b1;
      if (retire)   retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    set_halt  = 1'b0;
    set_ill   = 1'b0;
    case (state)
      ST_FETCH:  if (mem.imem_ack) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        case (cls)
          CLS_R, CLS_ADDI:       state_nxt = ST_WB;
          CLS_LD, CLS_ST:        state_nxt = ST_MEM;
          CLS_CBZ, CLS_CBNZ, CLS_B: begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end
          CLS_HALT: begin
            state_nxt = ST_HALT;
            set_halt  = 1'b1;
            retire    = 1'b1;
          end
          default: begin
            state_nxt = ST_ERR;
            set_ill   = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (mem.dmem_ack) begin
          if (cls == CLS_ST) begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end else begin
            state_nxt = ST_WB;
          end
        end
      end
      ST_WB: begin
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = state;
    endcase
  end

  // Strobes are forced low during reset so an abandoned access drops at once.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg2loc      = 1'b0;
    alu_src_c    = ALUSRC_REG;
    alu_op       = ALUOP_ADD;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem.imem_req = 1'b1;
          ir_write     = mem.imem_ack;
          pc_write     = mem.imem_ack;
        end
        ST_DECODE: reg2loc = (cls == CLS_ST) || (cls == CLS_CBZ) || (cls == CLS_CBNZ);
        ST_EXEC: begin
          case (cls)
            CLS_R:    alu_op = ALUOP_FUNCT;
            CLS_ADDI: begin
              alu_op    = ALUOP_FUNCT;
              alu_src_c = ALUSRC_IMM;
            end
            CLS_LD, CLS_ST: alu_src_c = ALUSRC_DOFS;
            CLS_CBZ, CLS_CBNZ: begin
              alu_op   = ALUOP_PASS_B;
              reg2loc  = 1'b1;
              pc_write = taken;
              pc_src   = taken;
            end
            CLS_B: begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem.dmem_req = 1'b1;
          mem.dmem_we  = (cls == CLS_ST);
          alu_src_c    = ALUSRC_DOFS;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls == CLS_LD);
        end
        default: ;
      endcase
    end
  end

  assign alu_src = ADDR_SEL_W'(alu_src_c);

endmodule

// File: doc/cpu_multicycle_ctrl.md
Name: cpu_multicycle_ctrl

Overview:
Multi-cycle sequencer for the LEGv8 CPU datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the per-cycle datapath strobes (PC, IR, register file, ALU, data memory). It uses req/ack handshakes to both memories, so slow memories stall the sequence. It lets the datapath share a single ALU and run with wait-state memories, and it counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
ADDR_SEL_W, 2, width of alu_src select (00 reg, 01 D-type offset, 10 ALU immediate)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
inst31_21  input  11  opcode field from instruction register (valid from DECODE onward)
alu_zero  input  1  ALU zero flag, sampled in EXEC
imem_ack  input  1  instruction memory data valid
dmem_ack  input  1  data memory read data valid / write accepted
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory access request
dmem_we  output  1  data access is a write (qualifies dmem_req)
ir_write  output  1  load instruction register
pc_write  output  1  update PC
pc_src  output  1  0 = PC+4, 1 = branch target
reg2loc  output  1  second read register from Rt field
alu_src  output  ADDR_SEL_W  ALU B operand select
alu_op  output  2  00 add, 01 pass-B/compare, 10 funct-decoded
mem_to_reg  output  1  writeback data from memory
reg_write  output  1  register file write enable
halted  output  1  HALT executed; sticky
illegal  output  1  undecodable opcode; sticky
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset: clk edge with rst_n=0 sets state=FETCH, halted=0, illegal=0, retired=0. All strobes are 0 while rst_n=0. Reset mid-access abandons it; late acks are ignored.
- Opcode classes:
  - LDUR 11111000010; STUR 11111000000.
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - ADDI 1001000100x.
  - CBZ 10110100xxx; CBNZ 10110101xxx.
  - B 000101xxxxx; HALT 11111111111.
  - Anything else is ILLEGAL.
- Strobes are combinational from state, class and ack (Moore plus ack qualification). State, halted, illegal and retired are registered.
- FETCH: imem_req=1. On imem_ack: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Without ack, hold.
- DECODE (1 cycle): reg2loc=1 for STUR/CBZ/CBNZ. Go to EXEC.
- EXEC (1 cycle), by class:
  - R-type: alu_op=10, alu_src=00; go to WB.
  - ADDI: alu_op=10, alu_src=10; go to WB.
  - LDUR/STUR: alu_op=00, alu_src=01; go to MEM.
  - CBZ/CBNZ: alu_op=01, reg2loc=1. Taken when alu_zero=1 (CBZ) or alu_zero=0 (CBNZ); if taken, pc_write=1, pc_src=1. Retire, go to FETCH.
  - B: pc_write=1, pc_src=1. Retire, go to FETCH.
  - HALT: go to HALT_S, halted<=1, retire.
  - ILLEGAL: go to ERR_S, illegal<=1; not retired.
- MEM: dmem_req=1, dmem_we=1 for STUR; alu_op=00 and alu_src=01 held. On dmem_ack: LDUR goes to WB; STUR retires and goes to FETCH. Without ack, hold with request stable.
- WB (1 cycle): reg_write=1, mem_to_reg=1 iff LDUR. Retire, go to FETCH.
- HALT_S / ERR_S: terminal until reset. All strobes 0, acks ignored.
- Zero-wait latency: R/ADDI 4 cycles, LDUR 5, STUR 4, CB*/B 3, HALT 3. Each cycle an ack is withheld adds 1 cycle.
- retired increments by 1 on the retiring transition and wraps modulo 2^CNT_W.
- reg_write is never asserted for CB*/B/STUR/HALT. dmem_req and imem_req are never both 1.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants and don't-care masks;
  - class enum (CLS_LD, CLS_ST, CLS_R, CLS_ADDI, CLS_CBZ, CLS_CBNZ, CLS_B, CLS_HALT, CLS_ILL);
  - state enum;
  - ALUOp and ALUSrc encodings.
- One sub-module: cpu_opcode_class, a combinational inst31_21-to-class decoder that cpu_control can also reuse.

Test Plan:
- Reset then ADD, acks immediate -> imem_req cycle 0; ir_write+pc_write(pc_src=0) cycle 0; reg_write=1 cycle 3; retired=1 after cycle 3.
- LDUR with imem_ack delayed 2 cycles, dmem_ack delayed 3 -> imem_req held 3 cycles and dmem_req/dmem_we=0 held 4 cycles. reg_write and mem_to_reg=1 in the single WB cycle; total 10 cycles.
- CBZ with alu_zero=1 -> pc_write=1 and pc_src=1 in EXEC. CBNZ with alu_zero=1 -> no pc_write in EXEC; both retire in 3 cycles; reg_write never 1.
- STUR then HALT -> dmem_we=1 with dmem_req; halted=1 after HALT EXEC; retired=2. Further imem_ack pulses produce no strobes.
- Opcode 11'b00000000000 -> illegal=1, retired unchanged, all strobes 0 thereafter. rst_n=0 for 1 cycle -> illegal=0, state FETCH.
- rst_n asserted while in MEM with dmem_req=1 -> next cycle dmem_req=0, imem_req=1. A dmem_ack arriving during FETCH is ignored.
